cic_decimator: RTL and testbench

//  Single-channel CIC decimation filter; two instances sit directly downstream of the mixer, one on the

---
 rtl/sdr_pkg.sv | 29 ++
 rtl/cic_comb_stage.sv | 39 +++
 rtl/cic_decimator.sv | 137 +++++++++++++
 tb/tb_cic_decimator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sdr_pkg.sv
// Shared definitions for the SDR receive chain (NCO, mixer, CIC decimators).
//   clog2_pow2() : exact log2 of a power-of-two constant
//   acc_width()  : CIC accumulator width = input width + bit growth
//   sample_t     : signed sample type shared by mixer, NCO and decimators
package sdr_pkg;

    localparam int SAMPLE_WIDTH = 12;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

    // Smallest r with 2**r >= value; exact log2 for powers of two.
    function automatic int clog2_pow2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width that holds a full-scale CIC response without ambiguity:
    // the input width plus N*log2(R) bits of growth.
    function automatic int acc_width(input int data_width, input int stages, input int decimation);
        return data_width + stages * clog2_pow2(decimation);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC differentiator (differential delay 1).
//   clk       : system clock
//   rst_n     : synchronous active-low reset, clears the delay and output
//   valid_in  : x_in holds a new decimated sample this cycle
//   x_in      : stage input
//   valid_out : y_out was updated on the last edge (valid_in delayed one cycle)
//   y_out     : x_in - previous valid x_in, modular WIDTH arithmetic
module cic_comb_stage #(
    parameter int WIDTH = 42
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] x_in,
    output logic                    valid_out,
    output logic signed [WIDTH-1:0] y_out
);

    logic signed [WIDTH-1:0] x_prev_r;

    // Difference against the previous decimated sample; the delay only advances on valid samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_prev_r  <= '0;
            y_out     <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                y_out    <= x_in - x_prev_r;
                x_prev_r <= x_in;
            end else begin
                y_out    <= y_out;
                x_prev_r <= x_prev_r;
            end
        end
    end

endmodule

// File: rtl/cic_decimator.sv
// Single-channel CIC decimation filter (N integrators, rate change R, M=1).
// Takes one signed sample every clock and emits one normalised sample per
// DECIMATION clocks, STAGES+1 cycles after the internal strobe.
//   clk            : system clock
//   rst_n          : synchronous active-low reset, clears all filter state
//   data_in        : signed input sample, consumed every cycle
//   data_out       : signed decimated sample, held between strobes
//   data_out_valid : one-cycle pulse when data_out updates
// Build option: define CIC_ROUND_EN for round-half-up with saturation on the
// output; otherwise the growth bits are simply truncated (toward -inf).
module cic_decimator
    import sdr_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int STAGES     = 3,
    parameter int DECIMATION = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         data_out_valid
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, STAGES, DECIMATION);
    localparam int GROWTH    = ACC_WIDTH - DATA_WIDTH;
    localparam int CNT_W     = clog2_pow2(DECIMATION);

    if (STAGES < 1 || STAGES > 6) begin : g_bad_stages
        $error("cic_decimator: STAGES must be in 1..6");
    end
    if (DECIMATION < 2 || DECIMATION > 4096 || (DECIMATION & (DECIMATION - 1)) != 0) begin : g_bad_decim
        $error("cic_decimator: DECIMATION must be a power of two in 2..4096");
    end

    logic signed [ACC_WIDTH-1:0]  data_ext_s;
    logic signed [ACC_WIDTH-1:0]  integ_r [STAGES];
    logic        [CNT_W-1:0]      cnt_r;
    logic                         strobe_s;
    logic signed [ACC_WIDTH-1:0]  comb_data_s [STAGES+1];
    logic                         comb_valid_s [STAGES+1];
    logic signed [ACC_WIDTH-1:0]  comb_out_s;
    logic signed [DATA_WIDTH-1:0] out_next_s;

    assign data_ext_s = {{GROWTH{data_in[DATA_WIDTH-1]}}, data_in};
    // DECIMATION is a power of two, so the last count is all ones.
    assign strobe_s   = (cnt_r == {CNT_W{1'b1}});

    // Integrator chain; each stage adds the previous stage's registered value, wrap-around is intended.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                integ_r[k] <= '0;
            end
        end else begin
            integ_r[0] <= integ_r[0] + data_ext_s;
            for (int k = 1; k < STAGES; k++) begin
                integ_r[k] <= integ_r[k] + integ_r[k-1];
            end
        end
    end

    // Decimation counter and capture of the last integrator into the comb input register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r           <= '0;
            comb_data_s[0]  <= '0;
            comb_valid_s[0] <= 1'b0;
        end else begin
            cnt_r           <= cnt_r + CNT_W'(1'b1);
            comb_valid_s[0] <= strobe_s;
            if (strobe_s) begin
                comb_data_s[0] <= integ_r[STAGES-1];
            end else begin
                comb_data_s[0] <= comb_data_s[0];
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_comb
        cic_comb_stage #(
            .WIDTH(ACC_WIDTH)
        ) u_comb (
            .clk      (clk),
            .rst_n    (rst_n),
            .valid_in (comb_valid_s[g]),
            .x_in     (comb_data_s[g]),
            .valid_out(comb_valid_s[g+1]),
            .y_out    (comb_data_s[g+1])
        );
    end

    assign comb_out_s = comb_data_s[STAGES];

`ifdef CIC_ROUND_EN
    localparam logic [ACC_WIDTH-1:0] ROUND_HALF = ACC_WIDTH'(1'b1) << (GROWTH - 1);

    logic signed [ACC_WIDTH-1:0] rounded_s;
    logic                        ovf_s;

    // Round half up; only a positive value can overflow when the half-LSB is added.
    always_comb begin
        rounded_s = comb_out_s + ROUND_HALF;
        ovf_s     = ~comb_out_s[ACC_WIDTH-1] & rounded_s[ACC_WIDTH-1];
        if (ovf_s) begin
            out_next_s = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            out_next_s = rounded_s[ACC_WIDTH-1 -: DATA_WIDTH];
        end
    end
`else
    // The growth LSBs are dropped by design.
    logic [GROWTH-1:0] unused_lsb_s;
    assign unused_lsb_s = comb_out_s[GROWTH-1:0];

    // Truncation toward -inf: keep the top DATA_WIDTH bits.
    always_comb begin
        out_next_s = comb_out_s[ACC_WIDTH-1 -: DATA_WIDTH];
    end
`endif

    // Output register, updated once per decimated sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= comb_valid_s[STAGES];
            if (comb_valid_s[STAGES]) begin
                data_out <= out_next_s;
            end else begin
                data_out <= data_out;
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator (12 bit, N=3, R=8) plus a default-size instance fed DC -1.
// Reference: the CIC output equals the N-fold length-R boxcar sum of the input
// (impulse response built by convolution), scaled by 2^-GROWTH, decimated by R.
module tb_cic_decimator;

    localparam int DW = 12;
    localparam int N  = 3;
    localparam int R  = 8;
    localparam int G  = 9;                 // N*log2(R)
    localparam int L  = N * (R - 1) + 1;   // impulse response length

    typedef struct {
        longint due;
        int     val;
        bit     chk;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [DW-1:0] data_in;
    logic signed [DW-1:0] data_out;
    logic                 data_out_valid;
    logic signed [DW-1:0] big_in;
    logic signed [DW-1:0] big_out;
    logic                 big_valid;

    exp_t   exp_q[$];
    int     xs[$];
    longint h [L];
    longint edge_n      = 0;
    int     checks      = 0;
    int     errors      = 0;
    int     value_checks = 0;
    int     big_checks  = 0;
    int     big_cnt     = 0;

    cic_decimator #(.DATA_WIDTH(DW), .STAGES(N), .DECIMATION(R)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid)
    );

    cic_decimator u_big (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (big_in),
        .data_out      (big_out),
        .data_out_valid(big_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(posedge clk) begin
        if (!rst_n) big_cnt <= 0;
        else if (big_valid === 1'b1) big_cnt <= big_cnt + 1;
    end

    // Expected output for a boxcar^N window ending at input index t_end.
    function automatic int ref_out(input int t_end);
        longint v;
        v = 0;
        for (int j = 0; j < L; j++) begin
            if (t_end - j >= 0) v += h[j] * longint'(xs[t_end - j]);
        end
`ifdef CIC_ROUND_EN
        v = (v + (64'sd1 <<< (G - 1))) >>> G;
        if (v > 2047) v = 2047;
`else
        v = v >>> G;
`endif
        return int'(v);
    endfunction

    task automatic drive(input logic signed [DW-1:0] d, input logic rst);
        int   t;
        exp_t e;
        @(negedge clk);
        data_in = d;
        rst_n   = rst;
        if (!rst) begin
            xs.delete();
            while (exp_q.size() > 0 && exp_q[$].due > edge_n) void'(exp_q.pop_back());
        end else begin
            xs.push_back(int'(d));
            t = xs.size() - 1;
            if (t % R == R - 1) begin
                e.due = edge_n + 1 + N + 1;
                e.val = ref_out(t - N);
                e.chk = (t / R) >= N;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive_rand(input int n);
        logic signed [DW-1:0] r;
        for (int i = 0; i < n; i++) begin
            r = DW'($urandom_range(4095, 0));
            drive(r, 1'b1);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (data_out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: pulse at edge %0d, none expected", edge_n);
                end else begin
                    e = exp_q.pop_front();
                    if (e.due != edge_n) begin
                        errors++;
                        $display("FAIL pulse_time: got edge %0d, expected edge %0d", edge_n, e.due);
                    end else if (e.chk) begin
                        checks++;
                        value_checks++;
                        if ($isunknown(data_out) || int'(data_out) != e.val) begin
                            errors++;
                            $display("FAIL data_out: got %0d, expected %0d at edge %0d",
                                     data_out, e.val, edge_n);
                        end
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= edge_n) begin
                checks++;
                errors++;
                $display("FAIL missing_valid: no pulse at edge %0d", exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (big_valid === 1'b1 && big_cnt >= N) begin
                checks++;
                big_checks++;
                if (big_out !== -12'sd1) begin
                    errors++;
                    $display("FAIL big_dc: got %0d, expected -1", big_out);
                end
            end
        end
    end

    initial begin
        longint tmp [L];
        int     len;
        rst_n   = 1'b0;
        data_in = 12'sd2047;
        big_in  = -12'sd1;

        for (int j = 0; j < L; j++) h[j] = 0;
        h[0] = 1;
        len  = 1;
        for (int s = 0; s < N; s++) begin
            for (int j = 0; j < L; j++) tmp[j] = 0;
            for (int i = 0; i < len; i++)
                for (int k = 0; k < R; k++) tmp[i + k] += h[i];
            h = tmp;
            len += R - 1;
        end

        // Reset held with full-scale input: outputs stay cleared.
        for (int i = 0; i < 5; i++) begin
            drive(12'sd2047, 1'b0);
            @(posedge clk);
            #1;
            checks++;
            if (data_out !== 12'sd0 || data_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_out: got data %0d valid %0b, expected 0 and 0",
                         data_out, data_out_valid);
            end
        end

        // DC levels, including both full-scale extremes.
        for (int i = 0; i < 64; i++) drive(12'sd1, 1'b1);
        for (int i = 0; i < 64; i++) drive(-12'sd2048, 1'b1);
        for (int i = 0; i < 64; i++) drive(12'sd2047, 1'b1);
        // Short pulse then silence.
        for (int i = 0; i < 6; i++)  drive(12'sd1, 1'b1);
        for (int i = 0; i < 60; i++) drive(12'sd0, 1'b1);
        // Input-rate Nyquist tone.
        for (int i = 0; i < 64; i++) drive((i % 2 == 0) ? 12'sd1024 : -12'sd1024, 1'b1);

        // One-cycle reset while the counter is at 3.
        while (xs.size() % R != 3) drive_rand(1);
        drive(12'sd0, 1'b0);
        drive_rand(200);

        // Long full-scale DC: integrators wrap repeatedly.
        for (int i = 0; i < 10000; i++) drive(12'sd2047, 1'b1);
        drive_rand(600);
        for (int i = 0; i < 40; i++) drive(12'sd0, 1'b1);
        @(negedge clk);
        #1;

        checks++;
        if (value_checks < 1000) begin
            errors++;
            $display("FAIL value_count: got %0d, expected at least 1000", value_checks);
        end
        checks++;
        if (big_checks < 5) begin
            errors++;
            $display("FAIL big_count: got %0d, expected at least 5", big_checks);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
